alu_seq: RTL and testbench

Parametrised, registered successor to the combinational datapath ALU. Executes the same 5-bit opcode set on WIDTH-bit operands with a start/ready/done handshake. Logic and shift ops complete in one cycle; signed multiply and divide are iterative, one bit per cycle. Sits between the operand registers (A, Y) and the Z/HI/LO result registers in the processor datapath.

---
 rtl/alu_seq.sv | 181 ++++++++++++++++++
 tb/tb_alu_seq.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Registered ALU with start/ready/done handshake. Logic and shift ops finish in one cycle.
// Signed mul and div run one bit per cycle on magnitudes, followed by a sign-fix step.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 clear,
  input  logic                 start,
  input  logic [4:0]           opcode,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 ready,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result,
  output logic                 overflow,
  output logic                 zero,
  output logic                 div_by_zero
);
  localparam int SHW = $clog2(WIDTH);

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;
  state_t state, state_next;

  logic [SHW-1:0]     count;
  logic               is_div, neg_res, neg_rem;
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH:0]     hi;
  logic [WIDTH-1:0]   lo;

  logic [SHW-1:0]     shamt;
  logic [2*WIDTH-1:0] rot_r, rot_l;
  logic [WIDTH-1:0]   sc_lo, sc_hi, a_mag, b_mag;
  logic               sc_ov, sc_legal, sc_dbz, iter_op;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] prod, fix_res;
  logic [WIDTH-1:0]   quo, rem;

  // Single-cycle datapath and operand magnitudes
  always_comb begin
    shamt    = B[SHW-1:0];
    rot_r    = {A, A} >> shamt;
    rot_l    = {A, A} << shamt;
    a_mag    = A[WIDTH-1] ? -A : A;
    b_mag    = B[WIDTH-1] ? -B : B;
    sc_lo    = '0;
    sc_hi    = '0;
    sc_ov    = 1'b0;
    sc_legal = 1'b1;
    sc_dbz   = 1'b0;
    iter_op  = 1'b0;
    case (opcode)
      OP_ADD: begin
        sc_lo = A + B;
        sc_ov = (A[WIDTH-1] == B[WIDTH-1]) && (sc_lo[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        sc_lo = A - B;
        sc_ov = (A[WIDTH-1] != B[WIDTH-1]) && (sc_lo[WIDTH-1] != A[WIDTH-1]);
      end
      OP_AND:  sc_lo = A & B;
      OP_OR:   sc_lo = A | B;
      OP_SHR:  sc_lo = A >> shamt;
      OP_SHRA: sc_lo = $signed(A) >>> shamt;
      OP_SHL:  sc_lo = A << shamt;
      OP_ROR:  sc_lo = rot_r[WIDTH-1:0];
      OP_ROL:  sc_lo = rot_l[2*WIDTH-1:WIDTH];
      OP_NEG:  sc_lo = -A;
      OP_NOT:  sc_lo = ~A;
      OP_MUL:  iter_op = 1'b1;
      OP_DIV: begin
        if (B == '0) begin
          sc_lo  = '1;
          sc_hi  = A;
          sc_dbz = 1'b1;
        end else begin
          iter_op = 1'b1;
        end
      end
      default: sc_legal = 1'b0;
    endcase
  end

  // One iteration step for each algorithm, plus the final sign correction
  always_comb begin
    mul_sum   = hi + (lo[0] ? {1'b0, opnd} : '0);
    div_shift = {hi[WIDTH-1:0], lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd};
    prod      = {hi[WIDTH-1:0], lo};
    quo       = neg_res ? -lo : lo;
    rem       = neg_rem ? -hi[WIDTH-1:0] : hi[WIDTH-1:0];
    if (is_div) fix_res = {rem, quo};
    else        fix_res = neg_res ? -prod : prod;
  end

  always_comb begin
    state_next = state;
    ready      = (state == IDLE);
    case (state)
      IDLE: if (start && iter_op) state_next = ITER;
      ITER: if (count == SHW'(WIDTH - 1)) state_next = FIX;
      FIX:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      count       <= '0;
      is_div      <= 1'b0;
      neg_res     <= 1'b0;
      neg_rem     <= 1'b0;
      opnd        <= '0;
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      result      <= '0;
      overflow    <= 1'b0;
      zero        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && iter_op) begin
            is_div  <= (opcode == OP_DIV);
            neg_res <= A[WIDTH-1] ^ B[WIDTH-1];
            neg_rem <= A[WIDTH-1];
            opnd    <= (opcode == OP_DIV) ? b_mag : a_mag;
            lo      <= (opcode == OP_DIV) ? a_mag : b_mag;
            hi      <= '0;
            count   <= '0;
          end else if (start) begin
            done        <= 1'b1;
            result      <= {sc_hi, sc_lo};
            overflow    <= sc_ov;
            zero        <= sc_legal && ({sc_hi, sc_lo} == '0);
            div_by_zero <= sc_dbz;
          end
        end
        ITER: begin
          count <= count + 1'b1;
          if (is_div) begin
            // Restoring step: keep the difference only when it did not go negative
            hi <= div_diff[WIDTH] ? div_shift : div_diff;
            lo <= {lo[WIDTH-2:0], ~div_diff[WIDTH]};
          end else begin
            hi <= {1'b0, mul_sum[WIDTH:1]};
            lo <= {mul_sum[0], lo[WIDTH-1:1]};
          end
        end
        FIX: begin
          done        <= 1'b1;
          result      <= fix_res;
          overflow    <= 1'b0;
          zero        <= (fix_res == '0);
          div_by_zero <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq (WIDTH=32) with hand-computed expected values.
module tb_alu_seq;
  localparam logic [4:0] ADD = 5'b00011, SUB = 5'b00100, AND_ = 5'b00101;
  localparam logic [4:0] SHRA = 5'b01000, ROR = 5'b01010, ROL = 5'b01011;
  localparam logic [4:0] MUL = 5'b01111, DIV = 5'b10000, NOT_ = 5'b10010;

  logic        clock = 1'b0, clear = 1'b1, start = 1'b0;
  logic [4:0]  opcode = '0;
  logic [31:0] A = '0, B = '0;
  logic        ready, done, overflow, zero, div_by_zero;
  logic [63:0] result;

  int n_tests = 0;
  int n_fail  = 0;

  alu_seq #(.WIDTH(32)) dut (
    .clock(clock), .clear(clear), .start(start), .opcode(opcode),
    .A(A), .B(B), .ready(ready), .done(done), .result(result),
    .overflow(overflow), .zero(zero), .div_by_zero(div_by_zero)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one op, count edges from acceptance until done (bounded) and cycles with ready low.
  // With poke set, a competing start plus operand changes are driven mid-flight.
  task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit poke, output int lat, output int rlow);
    @(negedge clock);
    start = 1'b1; opcode = op; A = a; B = b;
    @(posedge clock); #1;
    start = 1'b0;
    lat = 1;
    rlow = (ready == 1'b0) ? 1 : 0;
    while (!done && lat < 100) begin
      if (poke && lat == 4) begin
        start = 1'b1; opcode = ADD; A = 32'd1; B = 32'd1;
      end else begin
        start = 1'b0;
      end
      @(posedge clock); #1;
      lat++;
      if (!ready) rlow++;
    end
    start = 1'b0;
    if (!done) check("timeout", 64'(lat), 64'd0);
    $display("[TB] op=%b A=%h B=%h -> result=%h ov=%b z=%b dbz=%b lat=%0d",
             op, a, b, result, overflow, zero, div_by_zero, lat);
  endtask

  int lat, rlow;
  bit done_seen;

  initial begin
    #12;
    check("reset_ready", 64'(ready), 64'd1);
    check("reset_done", 64'(done), 64'd0);
    check("reset_result", result, 64'd0);
    check("reset_flags", 64'({overflow, zero, div_by_zero}), 64'd0);
    @(negedge clock); clear = 1'b0;

    do_op(ADD, 32'h7FFFFFFF, 32'd1, 1'b0, lat, rlow);
    check("add_res", result, 64'h00000000_80000000);
    check("add_ov", 64'(overflow), 64'd1);
    check("add_lat", 64'(lat), 64'd1);

    do_op(MUL, 32'hFFFFFFFD, 32'd7, 1'b1, lat, rlow);
    check("mul_res", result, 64'hFFFFFFFF_FFFFFFEB);
    check("mul_lat", 64'(lat), 64'd34);
    check("mul_ready_low", 64'(rlow), 64'd33);
    check("mul_ready_at_done", 64'(ready), 64'd1);
    check("mul_ov", 64'(overflow), 64'd0);

    do_op(DIV, 32'hFFFFFFEF, 32'd5, 1'b0, lat, rlow);
    check("div_res", result, 64'hFFFFFFFE_FFFFFFFD);
    check("div_lat", 64'(lat), 64'd34);

    do_op(DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0, lat, rlow);
    check("div_minneg", result, 64'h00000000_80000000);
    check("div_minneg_flags", 64'({overflow, div_by_zero}), 64'd0);

    do_op(DIV, 32'd42, 32'd0, 1'b0, lat, rlow);
    check("dbz_res", result, 64'h0000002A_FFFFFFFF);
    check("dbz_flag", 64'(div_by_zero), 64'd1);
    check("dbz_lat", 64'(lat), 64'd1);

    do_op(ROR, 32'h80000001, 32'd33, 1'b0, lat, rlow);
    check("ror_res", result, 64'h00000000_C0000000);
    check("ror_dbz_clr", 64'(div_by_zero), 64'd0);

    do_op(SHRA, 32'h80000000, 32'd4, 1'b0, lat, rlow);
    check("shra_res", result, 64'h00000000_F8000000);
    check("shra_zero", 64'(zero), 64'd0);

    do_op(ROL, 32'h80000001, 32'd4, 1'b0, lat, rlow);
    check("rol_res", result, 64'h00000000_00000018);

    do_op(SUB, 32'h80000000, 32'd1, 1'b0, lat, rlow);
    check("sub_res", result, 64'h00000000_7FFFFFFF);
    check("sub_ov", 64'(overflow), 64'd1);

    do_op(AND_, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, lat, rlow);
    check("and_res", result, 64'h00000000_F000F000);

    do_op(NOT_, 32'hFFFFFFFF, 32'h12345678, 1'b0, lat, rlow);
    check("not_res", result, 64'd0);
    check("not_zero", 64'(zero), 64'd1);

    do_op(5'b00000, 32'd9, 32'd9, 1'b0, lat, rlow);
    check("illegal_res", result, 64'd0);
    check("illegal_zero", 64'(zero), 64'd0);
    check("illegal_done", 64'(done), 64'd1);

    // Back-to-back single-cycle ops: done stays high, then result holds
    @(negedge clock); start = 1'b1; opcode = ADD; A = 32'd1; B = 32'd2;
    @(posedge clock); #1;
    check("b2b_first", result, 64'd3);
    @(negedge clock); opcode = SUB; A = 32'd10; B = 32'd4;
    @(posedge clock); #1;
    start = 1'b0;
    check("b2b_done", 64'(done), 64'd1);
    check("b2b_second", result, 64'd6);
    @(posedge clock); #1;
    check("hold_done", 64'(done), 64'd0);
    check("hold_result", result, 64'd6);
    $display("[TB] back-to-back add/sub -> result=%h", result);

    // Abort a multiply with clear
    @(negedge clock); start = 1'b1; opcode = MUL; A = 32'd5; B = 32'd6;
    @(posedge clock); #1; start = 1'b0;
    repeat (9) @(posedge clock);
    #2 clear = 1'b1;
    #1;
    check("clr_ready", 64'(ready), 64'd1);
    check("clr_done", 64'(done), 64'd0);
    check("clr_result", result, 64'd0);
    check("clr_flags", 64'({overflow, zero, div_by_zero}), 64'd0);
    #2 clear = 1'b0;
    done_seen = 1'b0;
    repeat (40) begin
      @(posedge clock); #1;
      if (done) done_seen = 1'b1;
    end
    check("clr_no_done", 64'(done_seen), 64'd0);
    $display("[TB] clear during mul -> ready=%b result=%h", ready, result);

    do_op(ADD, 32'd2, 32'd3, 1'b0, lat, rlow);
    check("post_clr_add", result, 64'd5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
